// File: rtl/if_align_buffer.sv
// Instruction-fetch alignment buffer: 4-entry halfword FIFO that turns fetched
// 32-bit words into aligned 16/32-bit instructions with their PCs.
module if_align_buffer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] START_PC   = ADDR_WIDTH'(32'h8000_0000)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [31:0]           in_word,
  input  logic                  in_offset,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  output logic                  id_valid,
  output logic [31:0]           id_inst,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic                  id_is16,
  input  logic                  id_ready
);

  logic [15:0]           hw_q [4];
  logic [15:0]           hw_d [4];
  logic [1:0]            rd_q, rd_d;
  logic [1:0]            wr_q, wr_d;
  logic [2:0]            count_q, count_d;
  logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d;

  logic [15:0] head_hw;
  logic [15:0] next_hw;
  logic        head_c;
  logic        push;
  logic        pop;
  logic [2:0]  push_n;
  logic [2:0]  pop_n;

  // Outputs depend only on registered state; no input reaches id_* directly.
  always_comb begin
    head_hw  = hw_q[rd_q];
    next_hw  = hw_q[rd_q + 2'd1];
    head_c   = (head_hw[1:0] != 2'b11);
    in_ready = (count_q <= 3'd2);
    id_valid = ((count_q >= 3'd1) && head_c) || (count_q >= 3'd2);
    id_is16  = id_valid && head_c;
    id_pc    = head_pc_q;
    if (count_q == 3'd0) begin
      id_inst = 32'h0;
    end else if (head_c) begin
      id_inst = {16'h0, head_hw};
    end else begin
      id_inst = {next_hw, head_hw};
    end
  end

  always_comb begin
    hw_d      = hw_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;
    head_pc_d = head_pc_q;
    push      = in_valid && in_ready && !flush;
    pop       = id_valid && id_ready && !flush;
    push_n    = push ? (in_offset ? 3'd1 : 3'd2) : 3'd0;
    pop_n     = pop ? (head_c ? 3'd1 : 3'd2) : 3'd0;
    if (flush) begin
      rd_d      = 2'd0;
      wr_d      = 2'd0;
      count_d   = 3'd0;
      head_pc_d = flush_pc;
    end else begin
      if (push) begin
        if (in_offset) begin
          hw_d[wr_q] = in_word[31:16];
          wr_d       = wr_q + 2'd1;
        end else begin
          hw_d[wr_q]        = in_word[15:0];
          hw_d[wr_q + 2'd1] = in_word[31:16];
          wr_d              = wr_q + 2'd2;
        end
      end
      if (pop) begin
        rd_d      = head_c ? rd_q + 2'd1 : rd_q + 2'd2;
        head_pc_d = head_c ? head_pc_q + ADDR_WIDTH'(2) : head_pc_q + ADDR_WIDTH'(4);
      end
      count_d = count_q + push_n - pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hw_q      <= '{default: 16'h0};
      rd_q      <= 2'd0;
      wr_q      <= 2'd0;
      count_q   <= 3'd0;
      head_pc_q <= START_PC;
    end else begin
      hw_q      <= hw_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      count_q   <= count_d;
      head_pc_q <= head_pc_d;
    end
  end

endmodule

// File: tb/tb_if_align_buffer.sv
// Self-checking bench for if_align_buffer: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_if_align_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_word = 32'h0;
  logic        in_offset = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_is16;
  logic        id_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  if_align_buffer #(.ADDR_WIDTH(32), .START_PC(32'h8000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_word(in_word),
    .in_offset(in_offset), .in_ready(in_ready), .flush(flush), .flush_pc(flush_pc),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_is16(id_is16),
    .id_ready(id_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: halfwords in arrival order, head PC alongside.
  logic [15:0] mq[$];
  logic [31:0] mpc = 32'h8000_0000;

  function automatic bit m_c16();
    return (mq.size() >= 1) && (mq[0][1:0] != 2'b11);
  endfunction

  function automatic bit m_valid();
    return m_c16() || (mq.size() >= 2);
  endfunction

  always @(posedge clk) begin
    bit do_pop, do_push, c16;
    if (!rst_n) begin
      mq.delete();
      mpc = 32'h8000_0000;
    end else if (flush) begin
      mq.delete();
      mpc = flush_pc;
    end else begin
      do_pop  = m_valid() && id_ready;
      do_push = in_valid && (mq.size() <= 2);
      c16     = m_c16();
      if (do_pop) begin
        void'(mq.pop_front());
        if (!c16) void'(mq.pop_front());
        mpc = mpc + (c16 ? 32'd2 : 32'd4);
      end
      if (do_push) begin
        if (!in_offset) mq.push_back(in_word[15:0]);
        mq.push_back(in_word[31:16]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'h0, in_ready}, {31'h0, mq.size() <= 2});
      chk("id_valid", {31'h0, id_valid}, {31'h0, m_valid()});
      chk("id_is16", {31'h0, id_is16}, {31'h0, m_valid() && m_c16()});
      chk("id_pc", id_pc, mpc);
      if (mq.size() == 0) chk("id_inst_empty", id_inst, 32'h0);
      else if (m_c16()) chk("id_inst16", id_inst, {16'h0, mq[0]});
      else if (mq.size() >= 2) chk("id_inst32", id_inst, {mq[1], mq[0]});
    end
  end

  task automatic cyc(input bit v, input logic [31:0] w, input bit off,
                     input bit fl, input logic [31:0] fpc, input bit idr);
    in_valid = v; in_word = w; in_offset = off;
    flush = fl; flush_pc = fpc; id_ready = idr;
    @(negedge clk); #1;
  endtask

  task automatic idle(input bit idr);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, idr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    idle(1'b0);
    do_reset();
    chk_en = 1'b1;
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_is16", {31'h0, id_is16}, 32'h0);
    chk("rst_pc", id_pc, 32'h8000_0000);
    chk("rst_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_inst", id_inst, 32'h0);

    // single 32-bit instruction
    cyc(1'b1, 32'h0013_0513, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("t33_valid", {31'h0, id_valid}, 32'h1);
    chk("t33_inst", id_inst, 32'h0013_0513);
    chk("t33_pc", id_pc, 32'h8000_0000);
    chk("t33_is16", {31'h0, id_is16}, 32'h0);
    idle(1'b1);
    chk("t33_empty", {31'h0, id_valid}, 32'h0);
    chk("t33_pc2", id_pc, 32'h8000_0004);

    // two compressed in one word
    do_reset();
    cyc(1'b1, 32'h4501_4505, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("t34_inst0", id_inst, 32'h0000_4505);
    chk("t34_pc0", id_pc, 32'h8000_0000);
    chk("t34_is16_0", {31'h0, id_is16}, 32'h1);
    idle(1'b1);
    chk("t34_inst1", id_inst, 32'h0000_4501);
    chk("t34_pc1", id_pc, 32'h8000_0002);
    chk("t34_is16_1", {31'h0, id_is16}, 32'h1);

    // 32-bit instruction split across two words
    do_reset();
    cyc(1'b1, 32'h0513_4505, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t35_c_inst", id_inst, 32'h0000_4505);
    idle(1'b1);
    chk("t35_held", {31'h0, id_valid}, 32'h0);
    chk("t35_held_pc", id_pc, 32'h8000_0002);
    cyc(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("t35_valid", {31'h0, id_valid}, 32'h1);
    chk("t35_inst", id_inst, 32'h0013_0513);
    chk("t35_pc", id_pc, 32'h8000_0002);

    // fill to 4 halfwords, third word must be ignored
    do_reset();
    cyc(1'b1, 32'h0013_0513, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t36_rdy2", {31'h0, in_ready}, 32'h1);
    cyc(1'b1, 32'h0013_0513, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t36_full", {31'h0, in_ready}, 32'h0);
    cyc(1'b1, 32'h4505_4505, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t36_still_full", {31'h0, in_ready}, 32'h0);
    idle(1'b1);
    chk("t36_rdy_again", {31'h0, in_ready}, 32'h1);
    chk("t36_pc", id_pc, 32'h8000_0004);
    idle(1'b1);
    chk("t36_ignored", {31'h0, id_valid}, 32'h0);

    // flush beats same-cycle push and pop
    do_reset();
    cyc(1'b1, 32'h0013_0513, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h4501_4505, 1'b0, 1'b1, 32'h8000_0102, 1'b1);
    chk("t37_valid", {31'h0, id_valid}, 32'h0);
    chk("t37_pc", id_pc, 32'h8000_0102);
    chk("t37_inst", id_inst, 32'h0);
    cyc(1'b1, 32'h4505_1234, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t37_inst2", id_inst, 32'h0000_4505);
    chk("t37_pc2", id_pc, 32'h8000_0102);

    // head PC wraps
    do_reset();
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    cyc(1'b1, 32'h4505_0000, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t38_pc", id_pc, 32'hFFFF_FFFE);
    idle(1'b1);
    chk("t38_wrap", id_pc, 32'h0000_0000);

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] h0, h1;
      h0 = 16'($urandom);
      h1 = 16'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 2) != 0, {h1, h0}, 1'($urandom),
          $urandom_range(0, 15) == 0, {$urandom} & 32'hFFFF_FFFE,
          $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_align_buffer.md
IF_ALIGN_BUFFER -- requirements
Module: if_align_buffer

Interface
REQ-001 Parameter ADDR_WIDTH, 32, width of all PC signals.
REQ-002 Parameter START_PC, 32'h8000_0000, head PC loaded at reset.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  I-cache word valid this cycle.
REQ-006 in_word  input  32  fetched word; halfword0 = [15:0], halfword1 = [31:16].
REQ-007 in_offset  input  1  PC[1] of the fetch; 1 = only halfword1 valid.
REQ-008 in_ready  output  1  buffer can accept a word this cycle.
REQ-009 flush  input  1  redirect from EX branch, BP redirect or Ctrl exception.
REQ-010 flush_pc  input  ADDR_WIDTH  PC of first instruction after redirect.
REQ-011 id_valid  output  1  a complete instruction is presented to IFID.
REQ-012 id_inst  output  32  instruction; 16-bit ones zero-extended to [31:16].
REQ-013 id_pc  output  ADDR_WIDTH  PC of id_inst.
REQ-014 id_is16  output  1  presented instruction is compressed (drives Decode_16BitFlag path).
REQ-015 id_ready  input  1  IFID consumes (not stalled).

Function
REQ-016 Storage SHALL be a 4-entry halfword circular buffer with 2-bit rd/wr pointers and 3-bit count (0..4).
REQ-017 in_ready SHALL be combinational from registered state: 1 when count <= 2, independent of same-cycle pop.
REQ-018 Push SHALL occur when in_valid && in_ready && !flush: offset 0 writes halfword0 then halfword1 (+2); offset 1 writes halfword1 only (+1).
REQ-019 in_valid while in_ready = 0 SHALL be ignored; upstream holds or re-fetches.
REQ-020 Head halfword is compressed when bits[1:0] != 2'b11.
REQ-021 id_valid SHALL be 1 when count >= 1 and head compressed, or count >= 2; else 0.
REQ-022 id_inst SHALL be {16'b0, hw[rd]} when compressed, {hw[rd+1], hw[rd]} otherwise (pointer add mod 4).
REQ-023 id_pc SHALL equal head_pc register; id_is16 SHALL equal head-compressed flag, qualified by id_valid (0 when id_valid = 0).
REQ-024 Pop SHALL occur when id_valid && id_ready && !flush: rd += 1 and head_pc += 2 if compressed, rd += 2 and head_pc += 4 otherwise.
REQ-025 Simultaneous push and pop SHALL update count = count + pushed - popped in the same cycle; neither is lost.
REQ-026 A 32-bit instruction split across two words SHALL be held (id_valid = 0) until its upper halfword is pushed, then presented next cycle.
REQ-027 flush SHALL take priority over push and pop: next cycle count = 0, rd = wr = 0, head_pc = flush_pc; same-cycle in_word discarded.
REQ-028 head_pc arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-029 Outputs SHALL be pure functions of registered state (no in_* to id_* combinational path).

Reset
REQ-030 On rst_n = 0 at a clock edge: count = 0, rd = wr = 0, head_pc = START_PC, overriding flush and all handshakes.
REQ-031 During/after reset: id_valid = 0, id_is16 = 0, id_pc = START_PC, in_ready = 1; id_inst = 0 while count = 0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered halfwords with no instruction presented afterward until a new push.

Verification
REQ-033 Reset, push word 32'h0013_0513 offset 0, id_ready = 1 -> next cycle id_valid = 1, id_inst = 32'h0013_0513, id_pc = 32'h8000_0000, id_is16 = 0; after pop count = 0.
REQ-034 Push 32'h4501_4505 (two c.li) -> two cycles presenting id_inst 32'h0000_4505 @ 8000_0000 then 32'h0000_4501 @ 8000_0002, id_is16 = 1 both.
REQ-035 Push 32'h0513_4505 then 32'h0000_0013 -> c.li @ 8000_0000, then 32-bit 32'h0013_0513 @ 8000_0002 presented only after second push.
REQ-036 id_ready = 0, push two 32-bit words -> count = 4, in_ready = 0, third in_valid ignored; release id_ready -> in_ready = 1 once count <= 2.
REQ-037 flush = 1 with flush_pc = 32'h8000_0102 coincident with push and pop -> next cycle count = 0, id_valid = 0; push 32'h4505_xxxx offset 1 -> id_inst 32'h0000_4505 @ 8000_0102.
REQ-038 flush_pc = 32'hFFFF_FFFE, push compressed halfword offset 1 and pop -> head_pc wraps to 32'h0000_0000.
